mc_controller: RTL and testbench

Multicycle main control FSM for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and muxes. It also produces the 2-bit `aluop` consumed directly by the ALU decoder, which combines it with `funct` to form `alucontrol`. Memory accesses use a ready handshake, so slow memory stretches the affected states.

---
 rtl/mc_controller.sv | 156 +++++++++++++++
 tb/tb_mc_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables and muxes, stretching memory states until mem_ready.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_RTYPEEX = 4'd7;
  localparam logic [3:0] S_RTYPEWB = 4'd8;
  localparam logic [3:0] S_BEQEX   = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       pcwrite;
  logic       branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:    state_next = S_FETCH;
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decode from state; mem_ready gates the fetch-cycle writes, op only flags illegal.
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
          default:                                        illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction phase lists drive a per-cycle output model,
// plus literal spot checks of key signals and FETCH-to-FETCH cycle counts.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, iord, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, regwrite, regdst, memtoreg, illegal;

  int checks   = 0;
  int failures = 0;
  int cycles   = 0;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                 P_MEMWB = 5, P_MEMWR = 6, P_RTEX = 7, P_RTWB = 8, P_BEQ = 9,
                 P_ADDIEX = 10, P_ADDIWB = 11, P_JEX = 12;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } outs_t;

  outs_t act;
  assign act = outs_t'({mem_req, memwrite, irwrite, iord, alusrca, alusrcb, aluop, pcsrc,
                        pcen, regwrite, regdst, memtoreg, illegal});

  int         exp_phase = P_IDLE;
  bit         exp_on = 1'b0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // What each phase of an instruction must show on the control outputs.
  function automatic outs_t model(int ph, logic mr, logic z, logic [5:0] o);
    outs_t e;
    e = '0;
    case (ph)
      P_FETCH:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      P_DECODE: begin
        e.alusrcb = 2'b11;
        e.illegal = !(o inside {LW, SW, RT, BEQ, ADDI, J});
      end
      P_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      P_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      P_MEMWB:  begin e.regwrite = 1; e.memtoreg = 1; end
      P_MEMWR:  begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; end
      P_RTEX:   begin e.alusrca = 1; e.aluop = 2'b10; end
      P_RTWB:   begin e.regwrite = 1; e.regdst = 1; end
      P_BEQ:    begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
      P_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      P_ADDIWB: begin e.regwrite = 1; end
      P_JEX:    begin e.pcsrc = 2'b10; e.pcen = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      outs_t e;
      e = model(exp_phase, mem_ready, zero, op);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t phase=%0d act=%h req=%h", $time, exp_phase, act, e);
      end
    end
  end

  task automatic chk(string name, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t act=%h req=%h", name, $time, a, e);
    end
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Called at posedge+1; leaves time at posedge+4 so spot checks can follow.
  task automatic drive(int ph, logic mr, logic z, logic [5:0] o);
    exp_phase = ph;
    mem_ready = mr;
    zero      = z;
    op        = o;
    exp_on    = 1'b1;
    #3;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic run_instr(logic [5:0] o, int fw, int mw, logic z, int exp_len, string name);
    logic [5:0] junk;
    int         start;
    junk  = ~o;
    start = cycles;
    for (int i = 0; i < fw; i++) begin drive(P_FETCH, 1'b0, rnd(), junk); adv(); end
    drive(P_FETCH, 1'b1, rnd(), junk); adv();
    drive(P_DECODE, rnd(), rnd(), o);
    if (!(o inside {LW, SW, RT, BEQ, ADDI, J})) chk({name, "_illegal"}, 16'(illegal), 16'd1);
    adv();
    case (o)
      LW, SW: begin
        drive(P_MEMADR, rnd(), rnd(), o); adv();
        for (int i = 0; i <= mw; i++) begin
          drive((o == LW) ? P_MEMRD : P_MEMWR, (i == mw), rnd(), junk);
          if (o == LW) chk({name, "_memrd_iord"}, 16'({iord, mem_req}), 16'b11);
          else         chk({name, "_memwr"}, 16'({memwrite, mem_req, regwrite}), 16'b110);
          adv();
        end
        if (o == LW) begin drive(P_MEMWB, rnd(), rnd(), junk); adv(); end
      end
      RT:   begin drive(P_RTEX, rnd(), rnd(), junk); adv(); drive(P_RTWB, rnd(), rnd(), junk); adv(); end
      ADDI: begin drive(P_ADDIEX, rnd(), rnd(), junk); adv(); drive(P_ADDIWB, rnd(), rnd(), junk); adv(); end
      BEQ: begin
        drive(P_BEQ, rnd(), z, junk);
        chk({name, "_beq"}, 16'({pcen, pcsrc, aluop}), {11'd0, z, 4'b0101});
        adv();
      end
      J: begin
        drive(P_JEX, rnd(), rnd(), junk);
        chk({name, "_jex"}, 16'({pcen, pcsrc}), 16'b110);
        adv();
      end
      default: ;
    endcase
    chk({name, "_len"}, 16'(cycles - start), 16'(exp_len));
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = RT;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 16'(act), 16'h0000);

    // Release mid-cycle: the rest of this cycle is IDLE, FETCH follows.
    reset = 1'b1;
    drive(P_IDLE, 1'b1, 1'b0, RT);
    chk("idle_outs", 16'(act), 16'h0000);
    adv();
    drive(P_FETCH, 1'b1, 1'b0, RT);
    chk("nop_fetch", 16'({irwrite, pcen, alusrcb}), 16'b1101);
    adv();
    drive(P_DECODE, 1'b1, 1'b0, RT); adv();
    drive(P_RTEX, 1'b1, 1'b0, 6'h3f);
    chk("nop_aluop", 16'(aluop), 16'd2);
    adv();
    drive(P_RTWB, 1'b1, 1'b0, 6'h3f);
    chk("nop_wb", 16'({regwrite, regdst}), 16'b11);
    adv();

    run_instr(RT,   0, 0, 1'b0, 4, "rtype");
    run_instr(LW,   0, 2, 1'b0, 7, "lw_wait");
    run_instr(LW,   0, 0, 1'b0, 5, "lw");
    run_instr(BEQ,  0, 0, 1'b1, 3, "beq_taken");
    run_instr(BEQ,  2, 0, 1'b0, 5, "beq_fwait");
    run_instr(SW,   0, 0, 1'b0, 4, "sw");
    run_instr(SW,   1, 3, 1'b0, 8, "sw_wait");
    run_instr(J,    0, 0, 1'b0, 3, "j");
    run_instr(ADDI, 0, 0, 1'b0, 4, "addi");
    run_instr(6'h3f, 0, 0, 1'b0, 2, "illegal");
    run_instr(6'h01, 1, 0, 1'b0, 3, "illegal2");

    // Abort a stalled sw in MEMWR with an asynchronous reset.
    drive(P_FETCH, 1'b1, 1'b0, 6'h00); adv();
    drive(P_DECODE, 1'b0, 1'b0, SW); adv();
    drive(P_MEMADR, 1'b0, 1'b0, SW); adv();
    drive(P_MEMWR, 1'b0, 1'b0, 6'h00);
    chk("abort_memwr", 16'({memwrite, mem_req}), 16'b11);
    #2;
    exp_on = 1'b0;
    reset  = 1'b0;
    #1;
    chk("abort_async_zero", 16'(act), 16'h0000);
    adv();
    adv();
    chk("abort_held_zero", 16'(act), 16'h0000);
    reset = 1'b1;
    drive(P_IDLE, 1'b1, 1'b1, SW);
    chk("abort_idle", 16'(act), 16'h0000);
    adv();
    run_instr(ADDI, 0, 0, 1'b0, 4, "post_abort_addi");
    run_instr(LW,   1, 1, 1'b0, 7, "post_abort_lw");

    exp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
